processor18: RTL and testbench
==============================

# processor18

18-bit single-issue, multi-cycle processor core with an internal 16×18 register file. It fetches instructions through a read-only code port from an external synchronous program RAM. That RAM has one-cycle read latency: `dout` is registered from `addr` on each rising clock edge. The core executes one instruction every two clocks and exposes `halted` for the system bench.

## Interface

**Parameters**
- ADDR_SIZE, 18: width of the PC and of `code_addr`.
- WORD_SIZE, 18: width of data and instruction words. The instruction encoding requires 18.

**Ports**
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- code_addr, output, ADDR_SIZE: program-memory address. Combinationally equal to the PC.
- code_word, input, WORD_SIZE: registered RAM output for the address presented on the previous edge.
- halted, output, 1: high once a HALT instruction has executed.

## Operation

**State**
- `pc` (ADDR_SIZE bits).
- `state` ∈ {FETCH, EXEC}.
- `regs[0..15]`, 18 bits each.
- `halted` flag.

**State machine**
- FETCH: present `pc` on `code_addr`; the RAM latches the word at this edge. Next state is EXEC.
- EXEC: decode `code_word`, write the register, update `pc`. Next state is FETCH.
- `code_addr` stays equal to `pc` through both states.

**Encoding**
- op = [17:14], rd = [13:10], ra = [9:6], rb = [5:2].
- imm10 = [9:0], zero-extended. imm6 = [5:0], sign-extended. imm14 = [13:0], zero-extended.

**Opcodes** (default next PC is pc+1, modulo 2^ADDR_SIZE)
- 0 NOP.
- 1 LDI: rd ← imm10.
- 2 ADD: rd ← ra + rb.
- 3 SUB: rd ← ra − rb.
- 4 AND, 5 OR, 6 XOR: rd ← ra op rb.
- 7 MOV: rd ← ra.
- 8 ADDI: rd ← ra + imm6.
- 9 JMP: pc ← imm14.
- 10 JZ: if regs[rd]==0 then pc ← imm10.
- 11 JNZ: if regs[rd]!=0 then pc ← imm10.
- 12 SHL: rd ← ra<<1, zero fill.
- 13 SHR: rd ← ra>>1, logical.
- 14 HALT: halted ← 1; pc unchanged.
- 15: reserved, executes as NOP.

**Arithmetic and write rules**
- All arithmetic is modulo 2^18; no flags.
- Register reads in EXEC see values written by earlier instructions only.
- Only one register is written per instruction.
- r0 is an ordinary register, not hard-wired to zero.
- rd == ra is legal; the old ra value is used.

**Halt behaviour**
- Once `halted` is set, the core stays in FETCH/EXEC cycling with the PC frozen.
- No register writes occur while halted; execution is suppressed.
- Only reset clears `halted`.

## Timing

**Reset**
- On any edge with reset=1: pc=0, state=FETCH, all regs=0, halted=0.
- `code_addr` reads 0 during reset and on the first cycle after it.
- Reset overrides any in-progress EXEC; nothing is written on that edge.

**Latency**
- Instruction at address A is presented on `code_addr` in FETCH at cycle n. It executes at the end of cycle n+1.
- Its register result is visible from cycle n+2.
- Throughput is 2 clocks per instruction.

**Branches**
- A taken branch's target appears on `code_addr` in the cycle immediately after EXEC.
- There are no delay slots.

**Boundary conditions**
- pc = 2^ADDR_SIZE−1 followed by a non-branch instruction wraps pc to 0.
- `code_word` is ignored in FETCH.
- An X or uninitialised word in EXEC is not required to be meaningful. An all-zero word is a NOP.

## Test plan

- **Reset:** hold reset 3 clocks, then release.
  - `code_addr`=0 during reset and for the first clock after release.
  - All regs=0, halted=0.
- **ALU:** program 0x04012 (LDI r0,0x12), 0x04434 (LDI r1,0x34), 0x08804 (ADD r2,r0,r1).
  - After 6 clocks: r0=0x12, r1=0x34, r2=0x46.
  - `code_addr` sequence 0,0,1,1,2,2,3.
- **Wrap:** program LDI r1,1; SUB r2,r0,r1 with r0=0.
  - r2=0x3FFFF.
  - SHL of 0x3FFFF gives 0x3FFFE; SHR gives 0x1FFFF.
- **Loop/halt:** program LDI r0,3; ADDI r0,r0,−1; JNZ r0,1; HALT.
  - ADDI is taken 3 times; r0 ends at 0.
  - halted=1 and `code_addr` stays 3 indefinitely.
- **Jump:** program JMP 5 at address 0, with LDI r3,0x3FF at address 5 and LDI r3,1 at address 1.
  - r3=0x3FF; address 1 is never executed.
- **Reset mid-run:** assert reset during the EXEC of the ADD in the ALU scenario.
  - r2 remains 0 and pc=0.
  - The program then re-runs identically.

Source files
------------

// File: rtl/processor18.sv
// 18-bit multi-cycle core: FETCH presents pc to the program RAM, EXEC decodes the
// returned word, writes at most one register and advances pc. Two clocks per instruction.
module processor18 #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_SIZE-1:0] code_addr,
  input  logic [WORD_SIZE-1:0] code_word,
  output logic                 halted
);

  localparam logic FETCH = 1'b0;
  localparam logic EXEC  = 1'b1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_JZ   = 4'd10;
  localparam logic [3:0] OP_JNZ  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd14;

  logic                 state;
  logic [ADDR_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] regs [16];

  logic [3:0]           op;
  logic [3:0]           rd;
  logic [3:0]           ra;
  logic [3:0]           rb;
  logic [9:0]           imm10;
  logic [13:0]          imm14;
  logic [WORD_SIZE-1:0] rd_val;
  logic [WORD_SIZE-1:0] ra_val;
  logic [WORD_SIZE-1:0] rb_val;

  logic                 wr_en;
  logic [WORD_SIZE-1:0] wr_data;
  logic [ADDR_SIZE-1:0] pc_next;
  logic                 set_halt;

  function automatic logic [WORD_SIZE-1:0] sext6(input logic [5:0] v);
    logic signed [5:0]           s;
    logic signed [WORD_SIZE-1:0] w;
    s = signed'(v);
    w = WORD_SIZE'(s);
    return unsigned'(w);
  endfunction

  function automatic logic [WORD_SIZE-1:0] shl1(input logic [WORD_SIZE-1:0] v);
    return {v[WORD_SIZE-2:0], 1'b0};
  endfunction

  function automatic logic [WORD_SIZE-1:0] shr1(input logic [WORD_SIZE-1:0] v);
    return {1'b0, v[WORD_SIZE-1:1]};
  endfunction

  assign code_addr = pc;

  assign op     = code_word[17:14];
  assign rd     = code_word[13:10];
  assign ra     = code_word[9:6];
  assign rb     = code_word[5:2];
  assign imm10  = code_word[9:0];
  assign imm14  = code_word[13:0];
  assign rd_val = regs[rd];
  assign ra_val = regs[ra];
  assign rb_val = regs[rb];

  // Decode/execute: only meaningful while state == EXEC
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = '0;
    pc_next  = pc + ADDR_SIZE'(1);
    set_halt = 1'b0;
    case (op)
      OP_LDI:  begin wr_en = 1'b1; wr_data = WORD_SIZE'(imm10); end
      OP_ADD:  begin wr_en = 1'b1; wr_data = ra_val + rb_val; end
      OP_SUB:  begin wr_en = 1'b1; wr_data = ra_val - rb_val; end
      OP_AND:  begin wr_en = 1'b1; wr_data = ra_val & rb_val; end
      OP_OR:   begin wr_en = 1'b1; wr_data = ra_val | rb_val; end
      OP_XOR:  begin wr_en = 1'b1; wr_data = ra_val ^ rb_val; end
      OP_MOV:  begin wr_en = 1'b1; wr_data = ra_val; end
      OP_ADDI: begin wr_en = 1'b1; wr_data = ra_val + sext6(code_word[5:0]); end
      OP_JMP:  pc_next = ADDR_SIZE'(imm14);
      OP_JZ:   if (rd_val == '0) pc_next = ADDR_SIZE'(imm10);
      OP_JNZ:  if (rd_val != '0) pc_next = ADDR_SIZE'(imm10);
      OP_SHL:  begin wr_en = 1'b1; wr_data = shl1(ra_val); end
      OP_SHR:  begin wr_en = 1'b1; wr_data = shr1(ra_val); end
      OP_HALT: begin set_halt = 1'b1; pc_next = pc; end
      default: ;
    endcase
  end

  // Commit point: pc, halted and the single register write update at the end of EXEC
  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= '0;
      state  <= FETCH;
      halted <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (state == FETCH) begin
      state <= EXEC;
    end else begin
      state <= FETCH;
      if (!halted) begin
        pc <= pc_next;
        if (set_halt) halted <= 1'b1;
        if (wr_en) regs[rd] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_processor18.sv
// Directed bench for processor18: small program RAM model, hand-assembled programs,
// register contents observed through the hierarchy.
module tb_processor18;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] code_addr;
  logic [17:0] code_word = '0;
  logic        halted;

  logic [17:0] mem [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  processor18 #(.ADDR_SIZE(18), .WORD_SIZE(18)) dut (
    .clock     (clock),
    .reset     (reset),
    .code_addr (code_addr),
    .code_word (code_word),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  // Synchronous program RAM, one-cycle read latency
  always @(posedge clock)
    code_word <= (code_addr < 18'd32) ? mem[code_addr[4:0]] : 18'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 18'd0;
  endtask

  // Assert reset for three edges, release at a falling edge
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_addr", 32'(code_addr), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    reset = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [17:0] alu_seq  [7]  = '{18'd0, 18'd0, 18'd1, 18'd1, 18'd2, 18'd2, 18'd3};
  logic [17:0] jump_seq [10] = '{18'd0, 18'd0, 18'd5, 18'd5, 18'd6, 18'd6, 18'd8, 18'd8, 18'd9, 18'd9};

  initial begin
    int addr1_cnt;

    // ALU: LDI r0,0x12; LDI r1,0x34; ADD r2,r0,r1
    clear_mem();
    mem[0] = 18'h04012;
    mem[1] = 18'h04434;
    mem[2] = 18'h08804;
    do_reset();
    check("first_addr", 32'(code_addr), 32'h0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("alu_addr%0d", i), 32'(code_addr), 32'(alu_seq[i]));
      if (i < 6) cycles(1);
    end
    check("alu_r0", 32'(dut.regs[0]), 32'h12);
    check("alu_r1", 32'(dut.regs[1]), 32'h34);
    check("alu_r2", 32'(dut.regs[2]), 32'h46);

    // Reset asserted during EXEC of the ADD: nothing written, pc back to 0
    do_reset();
    cycles(5);
    check("mid_pre_addr", 32'(code_addr), 32'h2);
    reset = 1'b1;
    cycles(1);
    check("mid_r2", 32'(dut.regs[2]), 32'h0);
    check("mid_r0", 32'(dut.regs[0]), 32'h0);
    check("mid_pc", 32'(code_addr), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("rerun_addr%0d", i), 32'(code_addr), 32'(alu_seq[i]));
      if (i < 6) cycles(1);
    end
    check("rerun_r2", 32'(dut.regs[2]), 32'h46);

    // Wrap: LDI r1,1; SUB r2,r0,r1; SHL r3,r2; SHR r4,r2; HALT
    clear_mem();
    mem[0] = 18'h04401;
    mem[1] = 18'h0C804;
    mem[2] = 18'h30C80;
    mem[3] = 18'h35080;
    mem[4] = 18'h38000;
    do_reset();
    cycles(12);
    check("wrap_sub", 32'(dut.regs[2]), 32'h3FFFF);
    check("wrap_shl", 32'(dut.regs[3]), 32'h3FFFE);
    check("wrap_shr", 32'(dut.regs[4]), 32'h1FFFF);
    check("wrap_halted", 32'(halted), 32'h1);
    check("wrap_addr", 32'(code_addr), 32'h4);

    // Logic ops, MOV, ADDI with rd==ra, reserved opcode, HALT
    clear_mem();
    mem[0] = 18'h04012;
    mem[1] = 18'h04434;
    mem[2] = 18'h11404;
    mem[3] = 18'h15804;
    mem[4] = 18'h19C04;
    mem[5] = 18'h1E040;
    mem[6] = 18'h2047F;
    mem[7] = 18'h3E7FF;
    mem[8] = 18'h38000;
    do_reset();
    cycles(16);
    check("logic_not_halted", 32'(halted), 32'h0);
    cycles(6);
    check("logic_and", 32'(dut.regs[5]), 32'h10);
    check("logic_or",  32'(dut.regs[6]), 32'h36);
    check("logic_xor", 32'(dut.regs[7]), 32'h26);
    check("logic_mov", 32'(dut.regs[8]), 32'h34);
    check("logic_addi_rdra", 32'(dut.regs[1]), 32'h33);
    check("logic_reserved", 32'(dut.regs[9]), 32'h0);
    check("logic_halted", 32'(halted), 32'h1);
    check("logic_addr", 32'(code_addr), 32'h8);

    // Reset clears every register and the halt flag
    do_reset();
    for (int i = 0; i < 16; i++)
      check($sformatf("clr_r%0d", i), 32'(dut.regs[i]), 32'h0);

    // Loop: LDI r0,3; ADDI r0,r0,-1; JNZ r0,1; HALT
    clear_mem();
    mem[0] = 18'h04003;
    mem[1] = 18'h2003F;
    mem[2] = 18'h2C001;
    mem[3] = 18'h38000;
    do_reset();
    addr1_cnt = 0;
    for (int k = 0; k < 100 && !halted; k++) begin
      if (code_addr == 18'd1) addr1_cnt++;
      cycles(1);
    end
    check("loop_halted", 32'(halted), 32'h1);
    check("loop_addi_cycles", 32'(addr1_cnt), 32'd6);
    check("loop_r0", 32'(dut.regs[0]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycles(1);
      check($sformatf("loop_frozen%0d", k), 32'(code_addr), 32'h3);
    end
    check("loop_still_halted", 32'(halted), 32'h1);

    // Jump: JMP 5; taken JZ skips addr 7; untaken JZ falls through
    clear_mem();
    mem[0] = 18'h24005;
    mem[1] = 18'h04C01;
    mem[5] = 18'h04FFF;
    mem[6] = 18'h29008;
    mem[7] = 18'h04C01;
    mem[8] = 18'h28C00;
    mem[9] = 18'h38000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("jmp_addr%0d", i), 32'(code_addr), 32'(jump_seq[i]));
      cycles(1);
    end
    check("jmp_r3", 32'(dut.regs[3]), 32'h3FF);
    check("jmp_halted", 32'(halted), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
